// File: rtl/mem_req_ctrl_pkg.sv
// Shared widths, command record and FSM encoding for the memory request controller.
package mem_ctrl_pkg;
  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mem_cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} mem_ctrl_state_t;
endpackage

// File: rtl/mem_req_ctrl_if.sv
// Command, response and memory-side buses of mem_req_ctrl.
// master = command source / memory model side, slave = the controller.
interface mem_req_ctrl_if import mem_ctrl_pkg::*; ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  mem_enb;
  logic                  mem_rd_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_addr, rsp_rdata,
           mem_enb, mem_rd_wr, mem_addr, mem_data_in
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_addr, rsp_rdata,
           mem_enb, mem_rd_wr, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_req_ctrl_fifo.sv
// Command FIFO: wrap-around pointers with an extra MSB; can_push is a registered
// not-full flag, low during reset, and a same-cycle pop never frees a full FIFO.
module mem_cmd_fifo import mem_ctrl_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  mem_cmd_t                 din,
  input  logic                     pop,
  output mem_cmd_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     can_push
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr, level_nxt;
  mem_cmd_t    mem_q [DEPTH];

  assign level     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout      = mem_q[rd_ptr[AW-1:0]];
  assign level_nxt = level + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      can_push <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      can_push <= (level_nxt != (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mem_req_ctrl.sv
// Request-side controller for a 1-cycle registered single-port memory:
// FIFO-buffered commands, one access in flight, in-order read responses.
module mem_req_ctrl import mem_ctrl_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  mem_req_ctrl_if.slave                 bus,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_level,
  output logic                          busy
);
  mem_ctrl_state_t state_q, state_d;
  mem_cmd_t        cmd_in, head;
  logic            push, pop, full, empty, can_push;
  logic            cur_wr_q, cur_wr_d;
  logic            enb_q, enb_d, rd_wr_q, rd_wr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;

  assign cmd_in = '{wr: bus.req_wr, addr: bus.req_addr, wdata: bus.req_wdata};
  assign push   = bus.req_valid && can_push && !full;

  mem_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(cmd_in), .pop(pop), .dout(head),
    .full(full), .empty(empty), .level(cmd_level), .can_push(can_push)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    cur_wr_d    = cur_wr_q;
    enb_d       = enb_q;
    rd_wr_d     = rd_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: if (!empty) begin
        pop      = 1'b1;
        enb_d    = 1'b1;
        rd_wr_d  = ~head.wr;
        addr_d   = head.addr;
        wdata_d  = head.wdata;
        cur_wr_d = head.wr;
        state_d  = ISSUE;
      end
      ISSUE: begin
        enb_d   = 1'b0;
        rd_wr_d = 1'b1;
        state_d = cur_wr_q ? IDLE : CAPTURE;
      end
      // Memory output is only meaningful here; mem_addr still holds the read address.
      CAPTURE: begin
        rsp_rdata_d = bus.mem_data_out;
        rsp_addr_d  = addr_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_wr_q    <= 1'b0;
      enb_q       <= 1'b0;
      rd_wr_q     <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_wr_q    <= cur_wr_d;
      enb_q       <= enb_d;
      rd_wr_q     <= rd_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready   = can_push;
  assign bus.mem_enb     = enb_q;
  assign bus.mem_rd_wr   = rd_wr_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_addr    = rsp_addr_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign busy            = (state_q != IDLE) || !empty;
endmodule
